// File: rtl/mc_ctrl.sv
// Multi-cycle RV32-subset control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives ALU selects
// and datapath strobes, and bounds memory waits with an optional timeout.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [7:0]  zero,
    input  logic        mem_ready,
    output logic [4:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [4:0] ALU_NOP   = 5'b00000;
    localparam logic [4:0] ALU_LUI   = 5'b00001;
    localparam logic [4:0] ALU_AUIPC = 5'b00010;
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b01000;
    localparam logic [4:0] ALU_SRL   = 5'b01100;
    localparam logic [4:0] ALU_SRA   = 5'b11000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

    typedef struct packed {
        logic [4:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       illegal;
        logic       bus_err;
        logic [2:0] state;
    } ctrl_t;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_t       ctrl_s, ctrl_out_s;

    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic        is_lui_s, is_auipc_s, is_jal_s, is_br_s, is_lw_s, is_sw_s, is_alu_s;
    logic        alu_imm_s, legal_s, timeout_s, waiting_s;
    logic [4:0]  alu_sel_s;
    logic        unused_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];
    assign unused_s = ^{zero[7:1], instr[24:15], instr[11:7]};

    // Instruction classification and ALU operation for OP / OP-IMM
    always_comb begin
        is_lui_s   = 1'b0;
        is_auipc_s = 1'b0;
        is_jal_s   = 1'b0;
        is_br_s    = 1'b0;
        is_lw_s    = 1'b0;
        is_sw_s    = 1'b0;
        is_alu_s   = 1'b0;
        alu_imm_s  = 1'b0;
        alu_sel_s  = ALU_NOP;
        case (opcode_s)
            OPC_LUI:    is_lui_s   = 1'b1;
            OPC_AUIPC:  is_auipc_s = 1'b1;
            OPC_JAL:    is_jal_s   = 1'b1;
            OPC_BRANCH: is_br_s    = (f3_s == 3'b000) || (f3_s == 3'b001);
            OPC_LOAD:   is_lw_s    = (f3_s == 3'b010);
            OPC_STORE:  is_sw_s    = (f3_s == 3'b010);
            OPC_OPIMM: begin
                alu_imm_s = 1'b1;
                case (f3_s)
                    3'b000: begin is_alu_s = 1'b1; alu_sel_s = ALU_ADD; end
                    3'b001: begin is_alu_s = (f7_s == 7'h00); alu_sel_s = ALU_SLL; end
                    3'b101: begin
                        is_alu_s  = (f7_s == 7'h00) || (f7_s == 7'h20);
                        alu_sel_s = f7_s[5] ? ALU_SRA : ALU_SRL;
                    end
                    default: is_alu_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                case (f3_s)
                    3'b000: begin
                        is_alu_s  = (f7_s == 7'h00) || (f7_s == 7'h20);
                        alu_sel_s = f7_s[5] ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin is_alu_s = (f7_s == 7'h00); alu_sel_s = ALU_SLL; end
                    3'b101: begin
                        is_alu_s  = (f7_s == 7'h00) || (f7_s == 7'h20);
                        alu_sel_s = f7_s[5] ? ALU_SRA : ALU_SRL;
                    end
                    default: is_alu_s = 1'b0;
                endcase
            end
            default: is_alu_s = 1'b0;
        endcase
        legal_s = is_lui_s | is_auipc_s | is_jal_s | is_br_s | is_lw_s | is_sw_s | is_alu_s;
    end

    assign timeout_s = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign waiting_s = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready && !timeout_s;

    // Next-state and control decode
    always_comb begin
        ctrl_s       = '0;
        ctrl_s.state = state_q;
        state_d      = state_q;
        cnt_d        = waiting_s ? cnt_q + 1'b1 : '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_s.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    state_d         = ST_DECODE;
                end else if (timeout_s) begin
                    ctrl_s.bus_err = 1'b1;
                    state_d        = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (legal_s) begin
                    state_d = ST_EXEC;
                end else begin
                    ctrl_s.illegal = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (is_lui_s) begin
                    ctrl_s.alu_op    = ALU_LUI;
                    ctrl_s.alu_src_b = 2'd1;
                    state_d          = ST_WB;
                end else if (is_auipc_s) begin
                    ctrl_s.alu_op    = ALU_AUIPC;
                    ctrl_s.alu_src_b = 2'd2;
                    state_d          = ST_WB;
                end else if (is_alu_s) begin
                    ctrl_s.alu_op    = alu_sel_s;
                    ctrl_s.alu_src_b = {1'b0, alu_imm_s};
                    state_d          = ST_WB;
                end else if (is_lw_s || is_sw_s) begin
                    ctrl_s.alu_op    = ALU_ADD;
                    ctrl_s.alu_src_b = 2'd1;
                    state_d          = ST_MEM;
                end else if (is_jal_s) begin
                    ctrl_s.alu_op    = ALU_ADD;
                    ctrl_s.alu_src_a = 1'b1;
                    ctrl_s.alu_src_b = 2'd1;
                    ctrl_s.pc_write  = 1'b1;
                    ctrl_s.pc_src    = 2'd1;
                    state_d          = ST_WB;
                end else if (is_br_s) begin
                    // f3[0] distinguishes bne from beq
                    ctrl_s.alu_op   = ALU_SUB;
                    ctrl_s.pc_write = f3_s[0] ? ~zero[0] : zero[0];
                    ctrl_s.pc_src   = 2'd2;
                    ctrl_s.retire   = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                ctrl_s.alu_op    = ALU_ADD;
                ctrl_s.alu_src_b = 2'd1;
                ctrl_s.mem_read  = is_lw_s;
                ctrl_s.mem_write = ~is_lw_s;
                if (mem_ready) begin
                    ctrl_s.retire = ~is_lw_s;
                    state_d       = is_lw_s ? ST_WB : ST_FETCH;
                end else if (timeout_s) begin
                    ctrl_s.bus_err = 1'b1;
                    state_d        = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.wb_sel    = is_lw_s ? 2'd1 : (is_jal_s ? 2'd2 : 2'd0);
                ctrl_s.retire    = 1'b1;
                state_d          = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs forced quiet while reset is held
    always_comb begin
        if (rst) begin
            ctrl_out_s = '0;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign alu_op    = ctrl_out_s.alu_op;
    assign alu_src_a = ctrl_out_s.alu_src_a;
    assign alu_src_b = ctrl_out_s.alu_src_b;
    assign pc_write  = ctrl_out_s.pc_write;
    assign pc_src    = ctrl_out_s.pc_src;
    assign ir_write  = ctrl_out_s.ir_write;
    assign mem_read  = ctrl_out_s.mem_read;
    assign mem_write = ctrl_out_s.mem_write;
    assign reg_write = ctrl_out_s.reg_write;
    assign wb_sel    = ctrl_out_s.wb_sel;
    assign retire    = ctrl_out_s.retire;
    assign illegal   = ctrl_out_s.illegal;
    assign bus_err   = ctrl_out_s.bus_err;
    assign state     = ctrl_out_s.state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus random instruction streams checked against
// an instruction-level model of the control sequence.
module tb_mc_ctrl;

    localparam int TO = 4;

    logic        clk, rst, mem_ready;
    logic [31:0] instr;
    logic [7:0]  zero;
    logic [4:0]  alu_op;
    logic        alu_src_a, pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        retire, illegal, bus_err;
    logic [1:0]  alu_src_b, pc_src, wb_sel;
    logic [2:0]  state;
    logic [22:0] obs;
    int          checks = 0;
    int          errors = 0;

    mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .retire(retire), .illegal(illegal), .bus_err(bus_err),
        .state(state)
    );

    assign obs = {state, alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                  mem_read, mem_write, reg_write, wb_sel, retire, illegal, bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [22:0] expv(input logic [2:0] st, input logic [4:0] op,
            input logic sa, input logic [1:0] sb, input logic pw, input logic [1:0] ps,
            input logic irw, input logic mr, input logic mw, input logic rw,
            input logic [1:0] wb, input logic ret, input logic ill, input logic be);
        return {st, op, sa, sb, pw, ps, irw, mr, mw, rw, wb, ret, ill, be};
    endfunction

    // Instruction kinds: 0 illegal, 1 lui, 2 auipc, 3 jal, 4 beq, 5 bne, 6 lw, 7 sw, 8 alu
    function automatic void classify(input logic [31:0] ins, output int k,
                                     output logic [4:0] op, output logic imm);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        k = 0; op = 5'b00000; imm = 1'b0;
        if (opc == 7'b0110111) k = 1;
        else if (opc == 7'b0010111) k = 2;
        else if (opc == 7'b1101111) k = 3;
        else if (opc == 7'b1100011 && f3 == 3'b000) k = 4;
        else if (opc == 7'b1100011 && f3 == 3'b001) k = 5;
        else if (opc == 7'b0000011 && f3 == 3'b010) k = 6;
        else if (opc == 7'b0100011 && f3 == 3'b010) k = 7;
        else if (opc == 7'b0010011 || opc == 7'b0110011) begin
            imm = (opc == 7'b0010011);
            if (f3 == 3'b000 && imm) begin k = 8; op = 5'b00011; end
            else if (f3 == 3'b000 && f7 == 7'h00) begin k = 8; op = 5'b00011; end
            else if (f3 == 3'b000 && f7 == 7'h20) begin k = 8; op = 5'b00100; end
            else if (f3 == 3'b001 && f7 == 7'h00) begin k = 8; op = 5'b01000; end
            else if (f3 == 3'b101 && f7 == 7'h00) begin k = 8; op = 5'b01100; end
            else if (f3 == 3'b101 && f7 == 7'h20) begin k = 8; op = 5'b11000; end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        rst = 1'b1; instr = 32'h0; zero = 8'h00; mem_ready = 1'b0;
        step();
        @(negedge clk); checks++;
        if (obs !== 23'h0) begin errors++; $display("FAIL reset_hold got %h exp %h", obs, 23'h0); end
        step();
        rst = 1'b0;
        e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_release got %h exp %h", obs, e); end
        step();
    endtask

    task automatic test_add();
        logic [22:0] e;
        instr = 32'h002081B3; mem_ready = 1'b1;
        e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL add_fetch got %h exp %h", obs, e); end
        step();
        e = expv(3'd1, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL add_decode got %h exp %h", obs, e); end
        step();
        e = expv(3'd2, 5'b00011, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL add_exec got %h exp %h", obs, e); end
        step();
        e = expv(3'd4, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL add_wb got %h exp %h", obs, e); end
        step();
    endtask

    task automatic test_branch();
        logic [7:0]  zv [4] = '{8'h01, 8'h00, 8'hFE, 8'hFF};
        logic [22:0] e;
        logic [7:0]  z;
        for (int i = 0; i < 4; i++) begin
            z = zv[i];
            instr = 32'h00208463; zero = z; mem_ready = 1'b1;
            step();
            step();
            e = expv(3'd2, 5'b00100, 1'b0, 2'd0, z[0], 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
            @(negedge clk); checks++;
            if (obs !== e) begin errors++; $display("FAIL beq_exec zero=%h got %h exp %h", z, obs, e); end
            step();
            mem_ready = 1'b0;
            e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk); checks++;
            if (obs !== e) begin errors++; $display("FAIL beq_after zero=%h got %h exp %h", z, obs, e); end
            step();
        end
    endtask

    task automatic test_lw_sw();
        logic [22:0] e;
        instr = 32'h0000A183; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        e = expv(3'd2, 5'b00011, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL lw_exec got %h exp %h", obs, e); end
        step();
        e = expv(3'd3, 5'b00011, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk); checks++;
            if (obs !== e) begin errors++; $display("FAIL lw_mem cycle %0d got %h exp %h", i, obs, e); end
            step();
        end
        e = expv(3'd4, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL lw_wb got %h exp %h", obs, e); end
        step();
        instr = 32'h0020A023; mem_ready = 1'b1;
        step();
        step();
        step();
        e = expv(3'd3, 5'b00011, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL sw_mem got %h exp %h", obs, e); end
        step();
        mem_ready = 1'b0;
        e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL sw_after got %h exp %h", obs, e); end
        step();
    endtask

    task automatic test_illegal();
        logic [22:0] e;
        instr = 32'hFFFFFFFF; mem_ready = 1'b1;
        step();
        e = expv(3'd1, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL illegal_decode got %h exp %h", obs, e); end
        step();
        mem_ready = 1'b0;
        e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL illegal_after got %h exp %h", obs, e); end
        step();
    endtask

    task automatic test_timeout();
        logic [22:0] e;
        rst = 1'b1;
        step();
        rst = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < TO + 1; i++) begin
            e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0,
                     (i == TO - 1));
            @(negedge clk); checks++;
            if (obs !== e) begin errors++; $display("FAIL fetch_timeout cycle %0d got %h exp %h", i, obs, e); end
            step();
        end
    endtask

    task automatic test_rst_mid_mem();
        logic [22:0] e;
        instr = 32'h0020A023; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        e = expv(3'd3, 5'b00011, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mem_before got %h exp %h", obs, e); end
        step();
        rst = 1'b1;
        @(negedge clk); checks++;
        if (obs !== 23'h0) begin errors++; $display("FAIL rst_mem_hold got %h exp %h", obs, 23'h0); end
        step();
        rst = 1'b0;
        e = expv(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_mem_after got %h exp %h", obs, e); end
        step();
    endtask

    // Runs one instruction through the DUT and compares each cycle with the model
    task automatic run_instr(input logic [31:0] ins, input logic [7:0] z, input int flat, input int mlat);
        int k, ph, nxt, w, guard;
        logic [4:0] aop, op;
        logic imm, sa, pw, irw, mr, mw, rw, ret, ill, be;
        logic [1:0] sb, ps, wb;
        logic [22:0] e;
        classify(ins, k, aop, imm);
        instr = ins; zero = z;
        ph = 0; w = 0; guard = 0;
        while (ph != 5 && guard < 40) begin
            guard++;
            op = 5'd0; sa = 1'b0; sb = 2'd0; pw = 1'b0; ps = 2'd0; irw = 1'b0; mr = 1'b0;
            mw = 1'b0; rw = 1'b0; wb = 2'd0; ret = 1'b0; ill = 1'b0; be = 1'b0;
            nxt = 5;
            if (ph == 0) mem_ready = (w >= flat);
            else if (ph == 3) mem_ready = (w >= mlat);
            else mem_ready = 1'($urandom_range(0, 1));
            case (ph)
                0: begin
                    mr = 1'b1;
                    if (mem_ready) begin irw = 1'b1; pw = 1'b1; nxt = 1; end
                    else if (w == TO - 1) be = 1'b1;
                    else nxt = 0;
                end
                1: if (k == 0) ill = 1'b1; else nxt = 2;
                2: begin
                    nxt = 4;
                    if (k == 1) begin op = 5'b00001; sb = 2'd1; end
                    else if (k == 2) begin op = 5'b00010; sb = 2'd2; end
                    else if (k == 8) begin op = aop; sb = {1'b0, imm}; end
                    else if (k == 6 || k == 7) begin op = 5'b00011; sb = 2'd1; nxt = 3; end
                    else if (k == 3) begin op = 5'b00011; sa = 1'b1; sb = 2'd1; pw = 1'b1; ps = 2'd1; end
                    else begin
                        op = 5'b00100; ps = 2'd2; ret = 1'b1; nxt = 5;
                        pw = (k == 4) ? z[0] : ~z[0];
                    end
                end
                3: begin
                    op = 5'b00011; sb = 2'd1; mr = (k == 6); mw = (k == 7);
                    if (mem_ready) begin
                        if (k == 6) nxt = 4; else ret = 1'b1;
                    end else if (w == TO - 1) be = 1'b1;
                    else nxt = 3;
                end
                default: begin
                    rw = 1'b1; ret = 1'b1;
                    wb = (k == 6) ? 2'd1 : ((k == 3) ? 2'd2 : 2'd0);
                end
            endcase
            e = expv(3'(ph), op, sa, sb, pw, ps, irw, mr, mw, rw, wb, ret, ill, be);
            @(negedge clk); checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random instr=%h phase=%0d wait=%0d got %h exp %h", ins, ph, w, obs, e);
            end
            step();
            w = (nxt == ph) ? w + 1 : 0;
            ph = nxt;
        end
    endtask

    task automatic test_random();
        logic [6:0]  opcs [8] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b010, 3'b101};
        logic [31:0] ins;
        int c;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 150; n++) begin
            ins = $urandom();
            c = $urandom_range(0, 8);
            if (c < 8) ins[6:0] = opcs[c];
            c = $urandom_range(0, 4);
            if (c < 4) ins[14:12] = f3s[c];
            c = $urandom_range(0, 2);
            if (c == 0) ins[31:25] = 7'h00;
            else if (c == 1) ins[31:25] = 7'h20;
            run_instr(ins, 8'($urandom()), $urandom_range(0, 5), $urandom_range(0, 5));
        end
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; zero = 8'h00; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_branch();
        test_lw_sw();
        test_illegal();
        test_timeout();
        test_rst_mid_mem();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
